// File: rtl/nf10_upb_axis_pkt_gen_pkg.sv
// Shared types, widths and helpers for the AXI4-Stream test packet generator.
// Beat geometry is derived from the 256-bit stream width used across the pipeline.
package nf10_upb_axis_pkt_gen_pkg;

    localparam int DATA_W     = 256;
    localparam int BYTES      = DATA_W / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);
    localparam int LEN_W      = 14;
    localparam int COUNT_W    = 16;
    localparam int IFG_W      = 8;
    localparam int IN_PORT_W  = 3;
    localparam int OUT_PORT_W = 8;
    localparam int BEAT_W     = LEN_W - LOG2_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Low (len mod BYTES) lanes set; an exact multiple of BYTES fills the whole beat.
    function automatic logic [BYTES-1:0] last_tkeep(input logic [LEN_W-1:0] len);
        logic [LOG2_BYTES-1:0] r;
        logic [BYTES-1:0]      m;
        r = len[LOG2_BYTES-1:0];
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (r == '0) || (i < int'(r));
        end
        return m;
    endfunction

    // Index of the final beat, i.e. ceil(len/BYTES)-1; only valid for len != 0.
    function automatic logic [BEAT_W-1:0] last_beat_idx(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] len_m1;
        len_m1 = len - 1'b1;
        return len_m1[LEN_W-1:LOG2_BYTES];
    endfunction

endpackage

// File: rtl/nf10_upb_axis_pkt_gen_pattern.sv
// Payload pattern: byte i of beat b is (b*BYTES + i + seq) mod 256, masked lanes are 0.
module nf10_upb_axis_pkt_gen_pattern
    import nf10_upb_axis_pkt_gen_pkg::*;
(
    input  logic [BEAT_W-1:0] beat,
    input  logic [7:0]        seq,
    input  logic [BYTES-1:0]  keep,
    output logic [DATA_W-1:0] tdata
);

    logic [BEAT_W-1:0] beat_shift;
    logic [7:0]        beat_base;

    // Only the low byte of b*BYTES matters after the mod-256 wrap.
    assign beat_shift = beat << LOG2_BYTES;
    assign beat_base  = beat_shift[7:0];

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            assign tdata[gi*8 +: 8] = keep[gi] ? (beat_base + 8'(gi) + seq) : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/nf10_upb_axis_pkt_gen.sv
// Active AXI4-Stream packet generator: programmable length, count, ports and
// inter-frame gap; all stream outputs are registered and held until handshake.
module nf10_upb_axis_pkt_gen
    import nf10_upb_axis_pkt_gen_pkg::*;
#(
    parameter int axis_data_width                = 256,
    parameter int axis_tkeep_width               = 32,
    parameter int axis_tuser_in_port_width       = 3,
    parameter int axis_tuser_out_port_width      = 8,
    parameter int axis_tuser_packet_length_width = 14
)
(
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [axis_tuser_packet_length_width-1:0] cfg_pkt_len,
    input  logic [15:0]                               cfg_pkt_count,
    input  logic [7:0]                                cfg_ifg,
    input  logic [axis_tuser_in_port_width-1:0]       cfg_in_port,
    input  logic [axis_tuser_out_port_width-1:0]      cfg_out_port,
    output logic                                      busy,
    output logic                                      done,
    output logic [15:0]                               pkts_sent,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [axis_data_width-1:0]                m_axis_tdata,
    output logic [axis_tkeep_width-1:0]               m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [axis_tuser_packet_length_width-1:0] m_axis_tuser_packet_length,
    output logic [axis_tuser_in_port_width-1:0]       m_axis_tuser_in_port,
    output logic [axis_tuser_in_port_width-1:0]       m_axis_tuser_in_vport,
    output logic [axis_tuser_out_port_width-1:0]      m_axis_tuser_out_port,
    output logic [axis_tuser_out_port_width-1:0]      m_axis_tuser_out_vport
);

    // Reset asserts asynchronously but releases two clocks after reset_n rises.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];

    state_t                state_reg,     state_next;
    logic [LEN_W-1:0]      len_reg,       len_next;
    logic [COUNT_W-1:0]    count_reg,     count_next;
    logic [IFG_W-1:0]      ifg_reg,       ifg_next;
    logic [IN_PORT_W-1:0]  in_port_reg,   in_port_next;
    logic [OUT_PORT_W-1:0] out_port_reg,  out_port_next;
    logic [BEAT_W-1:0]     last_idx_reg,  last_idx_next;
    logic [BEAT_W-1:0]     beat_reg,      beat_next;
    logic [7:0]            seq_reg,       seq_next;
    logic [IFG_W-1:0]      gap_reg,       gap_next;
    logic [COUNT_W-1:0]    pkts_sent_reg, pkts_sent_next;
    logic                  abort_req_reg, abort_req_next;
    logic                  tvalid_reg,    tvalid_next;
    logic                  tlast_reg,     tlast_next;
    logic [BYTES-1:0]      tkeep_reg,     tkeep_next;
    logic [DATA_W-1:0]     tdata_reg,     tdata_next;
    logic                  busy_reg,      busy_next;
    logic                  done_reg,      done_next;

    logic                  hs;
    logic                  load_beat;
    logic                  stop_req;
    logic [COUNT_W-1:0]    pkts_inc;
    logic                  beat_is_last;
    logic [BYTES-1:0]      keep_new;
    logic [DATA_W-1:0]     pattern_data;

    assign hs       = tvalid_reg & m_axis_tready;
    assign pkts_inc = pkts_sent_reg + 1'b1;
    // A pulse of abort anywhere in the packet is remembered until the packet ends.
    assign stop_req = abort | abort_req_reg;

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        count_next     = count_reg;
        ifg_next       = ifg_reg;
        in_port_next   = in_port_reg;
        out_port_next  = out_port_reg;
        last_idx_next  = last_idx_reg;
        beat_next      = beat_reg;
        seq_next       = seq_reg;
        gap_next       = gap_reg;
        pkts_sent_next = pkts_sent_reg;
        abort_req_next = abort_req_reg;
        load_beat      = 1'b0;

        case (state_reg)
            IDLE: begin
                abort_req_next = 1'b0;
                if (start) begin
                    pkts_sent_next = '0;
                    if ((cfg_pkt_len != '0) && (cfg_pkt_count != '0)) begin
                        len_next      = cfg_pkt_len;
                        count_next    = cfg_pkt_count;
                        ifg_next      = cfg_ifg;
                        in_port_next  = cfg_in_port;
                        out_port_next = cfg_out_port;
                        last_idx_next = last_beat_idx(cfg_pkt_len);
                        beat_next     = '0;
                        seq_next      = '0;
                        load_beat     = 1'b1;
                        state_next    = SEND;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    abort_req_next = 1'b1;
                end
                if (hs) begin
                    if (tlast_reg) begin
                        pkts_sent_next = pkts_inc;
                        if ((pkts_inc == count_reg) || stop_req) begin
                            state_next = FIN;
                        end else if (ifg_reg == '0) begin
                            beat_next = '0;
                            seq_next  = pkts_inc[7:0];
                            load_beat = 1'b1;
                        end else begin
                            gap_next   = ifg_reg;
                            state_next = GAP;
                        end
                    end else begin
                        beat_next = beat_reg + 1'b1;
                        load_beat = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop_req) begin
                    state_next = FIN;
                end else if (gap_reg == 8'd1) begin
                    beat_next  = '0;
                    seq_next   = pkts_sent_reg[7:0];
                    load_beat  = 1'b1;
                    state_next = SEND;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            FIN: begin
                abort_req_next = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign beat_is_last = (beat_next == last_idx_next);
    assign keep_new     = beat_is_last ? last_tkeep(len_next) : {BYTES{1'b1}};

    nf10_upb_axis_pkt_gen_pattern u_pattern (
        .beat  (beat_next),
        .seq   (seq_next),
        .keep  (keep_new),
        .tdata (pattern_data)
    );

    // Beat registers only move on a handshake or a fresh packet load.
    always_comb begin
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        tkeep_next  = tkeep_reg;
        tdata_next  = tdata_reg;
        if (load_beat) begin
            tvalid_next = 1'b1;
            tlast_next  = beat_is_last;
            tkeep_next  = keep_new;
            tdata_next  = pattern_data;
        end else if (hs) begin
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            tkeep_next  = '0;
            tdata_next  = '0;
        end
        busy_next = (state_next == SEND) || (state_next == GAP);
        done_next = (state_next == FIN);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            ifg_reg       <= '0;
            in_port_reg   <= '0;
            out_port_reg  <= '0;
            last_idx_reg  <= '0;
            beat_reg      <= '0;
            seq_reg       <= '0;
            gap_reg       <= '0;
            pkts_sent_reg <= '0;
            abort_req_reg <= 1'b0;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tkeep_reg     <= '0;
            tdata_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            ifg_reg       <= ifg_next;
            in_port_reg   <= in_port_next;
            out_port_reg  <= out_port_next;
            last_idx_reg  <= last_idx_next;
            beat_reg      <= beat_next;
            seq_reg       <= seq_next;
            gap_reg       <= gap_next;
            pkts_sent_reg <= pkts_sent_next;
            abort_req_reg <= abort_req_next;
            tvalid_reg    <= tvalid_next;
            tlast_reg     <= tlast_next;
            tkeep_reg     <= tkeep_next;
            tdata_reg     <= tdata_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign busy                       = busy_reg;
    assign done                       = done_reg;
    assign pkts_sent                  = pkts_sent_reg;
    assign m_axis_tvalid              = tvalid_reg;
    assign m_axis_tdata               = tdata_reg;
    assign m_axis_tkeep               = tkeep_reg;
    assign m_axis_tlast               = tlast_reg;
    assign m_axis_tuser_packet_length = len_reg;
    assign m_axis_tuser_in_port       = in_port_reg;
    assign m_axis_tuser_in_vport      = in_port_reg;
    assign m_axis_tuser_out_port      = out_port_reg;
    assign m_axis_tuser_out_vport     = '0;

endmodule

// File: tb/tb_nf10_upb_axis_pkt_gen.sv
// Directed bench for the packet generator with a beat scoreboard fed from a reference model.
module tb_nf10_upb_axis_pkt_gen;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [13:0]  cfg_pkt_len = '0;
    logic [15:0]  cfg_pkt_count = '0;
    logic [7:0]   cfg_ifg = '0;
    logic [2:0]   cfg_in_port = '0;
    logic [7:0]   cfg_out_port = '0;
    logic         busy;
    logic         done;
    logic [15:0]  pkts_sent;
    logic         tvalid;
    logic         tready;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tlast;
    logic [13:0]  plen;
    logic [2:0]   in_port;
    logic [2:0]   in_vport;
    logic [7:0]   out_port;
    logic [7:0]   out_vport;

    nf10_upb_axis_pkt_gen dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .start                      (start),
        .abort                      (abort),
        .cfg_pkt_len                (cfg_pkt_len),
        .cfg_pkt_count              (cfg_pkt_count),
        .cfg_ifg                    (cfg_ifg),
        .cfg_in_port                (cfg_in_port),
        .cfg_out_port               (cfg_out_port),
        .busy                       (busy),
        .done                       (done),
        .pkts_sent                  (pkts_sent),
        .m_axis_tvalid              (tvalid),
        .m_axis_tready              (tready),
        .m_axis_tdata               (tdata),
        .m_axis_tkeep               (tkeep),
        .m_axis_tlast               (tlast),
        .m_axis_tuser_packet_length (plen),
        .m_axis_tuser_in_port       (in_port),
        .m_axis_tuser_in_vport      (in_vport),
        .m_axis_tuser_out_port      (out_port),
        .m_axis_tuser_out_vport     (out_vport)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [13:0]  plen;
        logic [2:0]   inp;
        logic [7:0]   outp;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = 0;
    int    done_cyc = 0;
    int    exp_ifg = 0;
    int    gap_cnt = 0;
    int    gaps_seen = 0;
    int    tvalid_cnt = 0;
    bit    gap_mon = 0;
    bit    gap_active = 0;
    bit    ready_rand = 0;
    bit    ready_level = 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference packet: byte at absolute offset idx carries (idx + seq) mod 256 while idx < len.
    task automatic push_packet(input int len, input int k, input logic [2:0] inp, input logic [7:0] outp);
        int    nb;
        beat_t e;
        nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < 32; i++) begin
                int idx;
                idx = b * 32 + i;
                if (idx < len) begin
                    e.keep[i]        = 1'b1;
                    e.data[i*8 +: 8] = 8'((idx + (k % 256)) % 256);
                end
            end
            e.last = (b == nb - 1);
            e.plen = 14'(len);
            e.inp  = inp;
            e.outp = outp;
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int len, input int count, input int ifg, input logic [2:0] inp, input logic [7:0] outp);
        if (len != 0 && count != 0) begin
            for (int k = 0; k < count; k++) push_packet(len, k, inp, outp);
        end
        exp_ifg = ifg;
        @(posedge clk); #1;
        cfg_pkt_len   = 14'(len);
        cfg_pkt_count = 16'(count);
        cfg_ifg       = 8'(ifg);
        cfg_in_port   = inp;
        cfg_out_port  = outp;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        cfg_pkt_len   = 14'($urandom);
        cfg_pkt_count = 16'($urandom);
        cfg_ifg       = 8'($urandom);
        cfg_in_port   = 3'($urandom);
        cfg_out_port  = 8'($urandom);
        chk("busy_after_start", {255'd0, busy}, {255'd0, 1'(len != 0 && count != 0)});
    endtask

    task automatic wait_done(input int budget, input string tag, input bit timing);
        int n = 0;
        int seen = 0;
        int after = 0;
        while (n < budget && after < 3) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen++;
                done_cyc = cyc;
            end
            if (seen > 0) after++;
        end
        chk({tag, "_done_pulses"}, seen, 1);
        if (timing && seen == 1) chk({tag, "_done_latency"}, done_cyc, last_hs_cyc + 1);
        gap_active = 0;
    endtask

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'(ready_level);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: scoreboard pop on each handshake, stall stability, gap length.
    initial begin
        logic [255:0] p_data;
        logic [31:0]  p_keep;
        logic         p_last;
        logic [32:0]  p_user;
        bit           prev_stall;
        beat_t        e;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
                gap_active = 0;
            end else begin
                if (tvalid) tvalid_cnt++;
                if (prev_stall) begin
                    chk("stall_tvalid", {255'd0, tvalid}, {255'd0, 1'b1});
                    chk("stall_tdata", tdata, p_data);
                    chk("stall_keep_last_user", {plen, in_port, in_vport, out_port, out_vport, tkeep, tlast},
                        {p_user, p_keep, p_last});
                end
                if (gap_mon && gap_active) begin
                    if (!tvalid) begin
                        gap_cnt++;
                        chk("gap_busy", {255'd0, busy}, {255'd0, 1'b1});
                    end else begin
                        chk("ifg_len", gap_cnt, exp_ifg);
                        gaps_seen++;
                        gap_active = 0;
                    end
                end
                if (tvalid && tready) begin
                    chk("beat_expected", {255'd0, 1'(exp_q.size() != 0)}, {255'd0, 1'b1});
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        $display("beat cyc=%0d tkeep=%08h tlast=%0b byte0=%02h", cyc, tkeep, tlast, tdata[7:0]);
                        chk("tdata", tdata, e.data);
                        chk("tkeep", tkeep, e.keep);
                        chk("tlast", {255'd0, tlast}, {255'd0, e.last});
                        chk("tuser", {plen, in_port, in_vport, out_port, out_vport},
                            {e.plen, e.inp, e.inp, e.outp, 8'h00});
                        if (e.last) begin
                            last_hs_cyc = cyc;
                            if (exp_q.size() != 0) begin
                                gap_active = 1;
                                gap_cnt    = 0;
                            end
                        end
                    end
                end
                prev_stall = tvalid && !tready;
                p_data = tdata;
                p_keep = tkeep;
                p_last = tlast;
                p_user = {plen, in_port, in_vport, out_port, out_vport};
            end
        end
    end

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {255'd0, tvalid}, 256'd0);
        chk("rst_busy_done", {254'd0, busy, done}, 256'd0);
        chk("rst_pkts_sent", pkts_sent, 256'd0);
        chk("rst_tdata", tdata, 256'd0);
        chk("rst_keep_last_user", {plen, in_port, in_vport, out_port, out_vport, tkeep, tlast}, 256'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // 1: two full beats
        ready_rand = 0; ready_level = 1;
        run(64, 1, 0, 3'd5, 8'h04);
        wait_done(100, "t1", 1);
        chk("t1_pkts_sent", pkts_sent, 1);
        chk("t1_queue_left", exp_q.size(), 0);

        // 2: single-byte last beat
        run(65, 1, 0, 3'd2, 8'h10);
        wait_done(100, "t2", 1);
        chk("t2_pkts_sent", pkts_sent, 1);
        chk("t2_queue_left", exp_q.size(), 0);

        // 3: long packets under random backpressure, spurious start mid-run
        ready_rand = 1; gap_mon = 1; gaps_seen = 0;
        run(1500, 4, 0, 3'd1, 8'h81);
        repeat (20) @(posedge clk);
        #1;
        cfg_pkt_len = 14'd32; cfg_pkt_count = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3000, "t3", 1);
        chk("t3_pkts_sent", pkts_sent, 4);
        chk("t3_queue_left", exp_q.size(), 0);
        chk("t3_b2b_gaps", gaps_seen, 3);

        // 4: inter-frame gap of two cycles
        ready_rand = 0; ready_level = 1; gaps_seen = 0;
        run(60, 3, 2, 3'd6, 8'h20);
        wait_done(200, "t4", 1);
        chk("t4_pkts_sent", pkts_sent, 3);
        chk("t4_queue_left", exp_q.size(), 0);
        chk("t4_gaps_seen", gaps_seen, 2);
        gap_mon = 0;

        // 5: abort pulsed on the first beat of the second packet
        run(64, 5, 0, 3'd3, 8'h02);
        n = 0;
        while (pkts_sent != 16'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_pkt2", pkts_sent, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(200, "t5", 1);
        chk("t5_pkts_sent", pkts_sent, 2);
        chk("t5_queue_left", exp_q.size(), 6);
        exp_q.delete();

        // 6: reset during a stalled beat, then an empty run
        ready_level = 0;
        run(1500, 2, 0, 3'd4, 8'h40);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_tvalid_before_reset", {255'd0, tvalid}, {255'd0, 1'b1});
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_tvalid_busy", {254'd0, tvalid, busy}, 256'd0);
        chk("t6_rst_tdata", tdata, 256'd0);
        chk("t6_rst_keep_last_cnt", {pkts_sent, tkeep, tlast}, 256'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        ready_level = 1;
        tvalid_cnt = 0;
        run(100, 0, 0, 3'd1, 8'h01);
        wait_done(50, "t6", 0);
        chk("t6_no_tvalid", tvalid_cnt, 0);
        chk("t6_pkts_sent", pkts_sent, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
